// File: rtl/pipe_controller.sv
// Pipe obstacle generator, scroller and collision detector for the play/dead game state.
// Pipe positions advance once per frame_tick; collision is evaluated every clock.
module pipe_controller #(
  parameter int SCREEN_H     = 480,
  parameter int PIPE_W       = 64,
  parameter int PIPE_SPACING = 320,
  parameter int GAP_H        = 120,
  parameter int GAP_MIN      = 64,
  parameter int SPEED        = 2,
  parameter int BIRD_X       = 160,
  parameter int BIRD_SIZE    = 16,
  parameter int INIT_X       = 640
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        restart,
  input  logic [10:0] bird_y,
  output logic [10:0] pipe1_x,
  output logic [10:0] pipe2_x,
  output logic [10:0] pipe1_gap_y,
  output logic [10:0] pipe2_gap_y,
  output logic        collision,
  output logic        pass_pulse,
  output logic        running
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam logic [10:0] INIT1     = 11'(INIT_X);
  localparam logic [10:0] INIT2     = 11'(INIT_X + PIPE_SPACING);
  localparam logic [10:0] GAP_RST   = 11'(GAP_MIN + 128);
  localparam logic [10:0] SPD       = 11'(SPEED);
  localparam logic [10:0] WRAP      = 11'(2 * PIPE_SPACING);
  localparam logic [10:0] GMIN      = 11'(GAP_MIN);
  localparam logic [10:0] BX11      = 11'(BIRD_X);
  localparam logic [11:0] BX12      = 12'(BIRD_X);
  localparam logic [11:0] BIRD_R12  = 12'(BIRD_X + BIRD_SIZE);
  localparam logic [11:0] PW12      = 12'(PIPE_W);
  localparam logic [11:0] BS12      = 12'(BIRD_SIZE);
  localparam logic [11:0] GH12      = 12'(GAP_H);
  localparam logic [11:0] SH12      = 12'(SCREEN_H);
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  state_t      state_r, state_n;
  logic [7:0]  lfsr_r, lfsr_n;
  logic [10:0] p1_n, p2_n, g1_n, g2_n;
  logic [10:0] adv1_s, adv2_s;
  logic        coll_n, pass_n, run_n;
  logic        hit_s;

  // Taps x^8+x^6+x^5+x^4; a non-zero seed keeps the sequence out of the all-zero state.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [10:0] advance(input logic [10:0] x);
    logic [10:0] r;
    if (x < SPD) begin
      r = x - SPD + WRAP;
    end else begin
      r = x - SPD;
    end
    return r;
  endfunction

  // 12-bit compare so pipe_x + PIPE_W and bird_y + BIRD_SIZE cannot wrap.
  function automatic logic pipe_hit(input logic [10:0] px, input logic [10:0] gy,
                                    input logic [10:0] by);
    logic overlap;
    logic miss;
    overlap = ({1'b0, px} < BIRD_R12) && (BX12 < ({1'b0, px} + PW12));
    miss    = ({1'b0, by} < {1'b0, gy}) || (({1'b0, by} + BS12) > ({1'b0, gy} + GH12));
    return overlap && miss;
  endfunction

  assign adv1_s = advance(pipe1_x);
  assign adv2_s = advance(pipe2_x);
  assign hit_s  = pipe_hit(pipe1_x, pipe1_gap_y, bird_y) ||
                  pipe_hit(pipe2_x, pipe2_gap_y, bird_y) ||
                  (({1'b0, bird_y} + BS12) > SH12);

  // Next-state and next-output computation; restart outranks hit, hit outranks frame_tick.
  always_comb begin
    state_n = state_r;
    lfsr_n  = lfsr_next(lfsr_r);
    p1_n    = pipe1_x;
    p2_n    = pipe2_x;
    g1_n    = pipe1_gap_y;
    g2_n    = pipe2_gap_y;
    coll_n  = collision;
    pass_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        p1_n   = INIT1;
        p2_n   = INIT2;
        coll_n = 1'b0;
        if (!restart && start) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (restart) begin
          state_n = ST_IDLE;
          p1_n    = INIT1;
          p2_n    = INIT2;
          coll_n  = 1'b0;
        end else if (hit_s) begin
          state_n = ST_DEAD;
          coll_n  = 1'b1;
        end else if (frame_tick) begin
          state_n = ST_RUN;
          p1_n    = adv1_s;
          p2_n    = adv2_s;
          if (pipe1_x < SPD) begin
            g1_n = GMIN + {3'b000, lfsr_r};
          end else begin
            g1_n = pipe1_gap_y;
          end
          if (pipe2_x < SPD) begin
            g2_n = GMIN + {3'b000, lfsr_r};
          end else begin
            g2_n = pipe2_gap_y;
          end
          pass_n = (adv1_s == BX11) || (adv2_s == BX11);
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DEAD: begin
        if (restart) begin
          state_n = ST_IDLE;
          p1_n    = INIT1;
          p2_n    = INIT2;
          coll_n  = 1'b0;
        end else begin
          state_n = ST_DEAD;
          coll_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        p1_n    = INIT1;
        p2_n    = INIT2;
        coll_n  = 1'b0;
      end
    endcase
    run_n = (state_n == ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= LFSR_SEED;
      pipe1_x     <= INIT1;
      pipe2_x     <= INIT2;
      pipe1_gap_y <= GAP_RST;
      pipe2_gap_y <= GAP_RST;
      collision   <= 1'b0;
      pass_pulse  <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_r     <= state_n;
      lfsr_r      <= lfsr_n;
      pipe1_x     <= p1_n;
      pipe2_x     <= p2_n;
      pipe1_gap_y <= g1_n;
      pipe2_gap_y <= g2_n;
      collision   <= coll_n;
      pass_pulse  <= pass_n;
      running     <= run_n;
    end
  end

endmodule

// File: tb/tb_pipe_controller.sv
// Directed self-checking bench for pipe_controller: scrolling, pass pulse, wrap,
// pipe and floor collisions, restart priority and asynchronous reset.
module tb_pipe_controller;

  logic        clock;
  logic        reset;
  logic        frame_tick;
  logic        start;
  logic        restart;
  logic [10:0] bird_y;
  logic [10:0] pipe1_x;
  logic [10:0] pipe2_x;
  logic [10:0] pipe1_gap_y;
  logic [10:0] pipe2_gap_y;
  logic        collision;
  logic        pass_pulse;
  logic        running;

  int          checks;
  int          errors;
  int          pass_cnt;
  int          pass_tick;
  logic [7:0]  lfsr_m;
  logic [10:0] exp_gap;

  pipe_controller dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .restart     (restart),
    .bird_y      (bird_y),
    .pipe1_x     (pipe1_x),
    .pipe2_x     (pipe2_x),
    .pipe1_gap_y (pipe1_gap_y),
    .pipe2_gap_y (pipe2_gap_y),
    .collision   (collision),
    .pass_pulse  (pass_pulse),
    .running     (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference LFSR: x^8+x^6+x^5+x^4, seed A5, one step per clock.
  always @(posedge clock or negedge reset) begin
    if (!reset) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; pass_cnt = 0; pass_tick = -1;
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0; restart = 1'b0; bird_y = 11'd200;
    #12;
    check("rst_p1x", 32'(pipe1_x), 32'd640);
    check("rst_p2x", 32'(pipe2_x), 32'd960);
    check("rst_g1", 32'(pipe1_gap_y), 32'd192);
    check("rst_g2", 32'(pipe2_gap_y), 32'd192);
    check("rst_coll", 32'(collision), 32'd0);
    check("rst_pass", 32'(pass_pulse), 32'd0);
    check("rst_run", 32'(running), 32'd0);
    reset = 1'b1;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("idle_run", 32'(running), 32'd0);
    check("idle_p1x", 32'(pipe1_x), 32'd640);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_run", 32'(running), 32'd1);
    check("start_p1x", 32'(pipe1_x), 32'd640);

    // 240 ticks, bird alternating between the top and bottom edges of the gap.
    for (int k = 1; k <= 240; k++) begin
      bird_y = 11'd192;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("scroll_p1x", 32'(pipe1_x), 32'(640 - 2 * k));
      check("scroll_coll", 32'(collision), 32'd0);
      if (pass_pulse) begin
        pass_cnt++;
        pass_tick = k;
      end
      bird_y = 11'd296;
      step();
      check("gap_edge_coll", 32'(collision), 32'd0);
    end
    check("pass_count", 32'(pass_cnt), 32'd1);
    check("pass_tick", 32'(pass_tick), 32'd240);
    check("pass_drop", 32'(pass_pulse), 32'd0);
    check("p2x_240", 32'(pipe2_x), 32'd480);

    bird_y = 11'd200;
    for (int k = 241; k <= 245; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("pass_once", 32'(pass_pulse), 32'd0);
      step();
    end
    check("p1x_150", 32'(pipe1_x), 32'd150);

    // Bird one pixel above the gap while overlapping pipe1.
    bird_y = 11'd191;
    step();
    check("hit_coll", 32'(collision), 32'd1);
    check("hit_run", 32'(running), 32'd0);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    start = 1'b0;
    check("dead_p1x", 32'(pipe1_x), 32'd150);
    check("dead_coll", 32'(collision), 32'd1);
    check("dead_run", 32'(running), 32'd0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs1_p1x", 32'(pipe1_x), 32'd640);
    check("rs1_p2x", 32'(pipe2_x), 32'd960);
    check("rs1_coll", 32'(collision), 32'd0);
    check("rs1_run", 32'(running), 32'd0);
    check("rs1_g1", 32'(pipe1_gap_y), 32'd192);

    // Second run to the pipe1 wrap, bird resting on the gap bottom edge.
    bird_y = 11'd296;
    start = 1'b1;
    step();
    start = 1'b0;
    check("run2_run", 32'(running), 32'd1);
    for (int k = 1; k <= 320; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      check("run2_coll", 32'(collision), 32'd0);
    end
    check("pre_wrap_p1x", 32'(pipe1_x), 32'd0);
    check("pre_wrap_p2x", 32'(pipe2_x), 32'd320);
    exp_gap = 11'd64 + {3'b000, lfsr_m};
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("wrap_p1x", 32'(pipe1_x), 32'd638);
    check("wrap_p2x", 32'(pipe2_x), 32'd318);
    check("wrap_g1", 32'(pipe1_gap_y), 32'(exp_gap));
    check("wrap_g1_range", 32'((pipe1_gap_y >= 11'd65) && (pipe1_gap_y <= 11'd319)), 32'd1);
    check("wrap_g2", 32'(pipe2_gap_y), 32'd192);

    // Floor boundary.
    bird_y = 11'd464;
    step();
    check("floor464_coll", 32'(collision), 32'd0);
    check("floor464_run", 32'(running), 32'd1);
    bird_y = 11'd465;
    step();
    check("floor465_coll", 32'(collision), 32'd1);
    check("floor465_run", 32'(running), 32'd0);
    check("floor_p1x", 32'(pipe1_x), 32'd638);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs2_p1x", 32'(pipe1_x), 32'd640);
    check("rs2_p2x", 32'(pipe2_x), 32'd960);
    check("rs2_coll", 32'(collision), 32'd0);
    check("rs2_g1_kept", 32'(pipe1_gap_y), 32'(exp_gap));

    // Restart coinciding with a floor hit.
    bird_y = 11'd200;
    start = 1'b1;
    step();
    start = 1'b0;
    check("run3_run", 32'(running), 32'd1);
    bird_y = 11'd465;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs_hit_coll", 32'(collision), 32'd0);
    check("rs_hit_run", 32'(running), 32'd0);
    step();
    check("rs_hit_coll2", 32'(collision), 32'd0);

    // Asynchronous reset in the middle of a run.
    bird_y = 11'd200;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    check("run4_p1x", 32'(pipe1_x), 32'd636);
    check("run4_run", 32'(running), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_p1x", 32'(pipe1_x), 32'd640);
    check("arst_p2x", 32'(pipe2_x), 32'd960);
    check("arst_g1", 32'(pipe1_gap_y), 32'd192);
    check("arst_run", 32'(running), 32'd0);
    check("arst_coll", 32'(collision), 32'd0);
    check("arst_pass", 32'(pass_pulse), 32'd0);
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
